ue14500_wide_icu: RTL and testbench

//  Next-generation UE14500 industrial control unit: a WIDTH-bit result register (RR) replaces the 1-bit RR.

---
 rtl/ue14500_wide_icu_pkg.sv | 26 ++
 rtl/ue14500_wide_icu_if.sv | 38 +++
 rtl/ue14500_wide_icu_alu.sv | 43 ++++
 rtl/ue14500_wide_icu.sv | 131 +++++++++++++
 tb/tb_ue14500_wide_icu.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ue14500_wide_icu_pkg.sv
// Shared opcode and skip-state definitions for the wide UE14500 control unit.
package ue_icu_pkg;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP0 = 4'h0;
  localparam logic [OP_W-1:0] OP_LD   = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_ONE  = 4'h4;
  localparam logic [OP_W-1:0] OP_NAND = 4'h5;
  localparam logic [OP_W-1:0] OP_OR   = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h7;
  localparam logic [OP_W-1:0] OP_STO  = 4'h8;
  localparam logic [OP_W-1:0] OP_STOC = 4'h9;
  localparam logic [OP_W-1:0] OP_IEN  = 4'hA;
  localparam logic [OP_W-1:0] OP_OEN  = 4'hB;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_RTN  = 4'hD;
  localparam logic [OP_W-1:0] OP_SKZ  = 4'hE;
  localparam logic [OP_W-1:0] OP_NOPF = 4'hF;

  typedef enum logic {
    SKIP_RUN  = 1'b0,
    SKIP_PEND = 1'b1
  } skip_e;
endpackage

// File: rtl/ue14500_wide_icu_if.sv
// Instruction/data bus between the external sequencer (master) and the control unit (slave).
// ZF is present only when UE_ICU_ZFLAG_EN is defined.
interface ue14500_wide_icu_if #(
  parameter int WIDTH = 4
);
  import ue_icu_pkg::*;

  logic [OP_W-1:0]  IR;
  logic             IR_VALID;
  logic [WIDTH-1:0] DATAIN;
  logic             FL0;
  logic             JMP;
  logic             RTN;
  logic             FLF;
  logic [WIDTH-1:0] DATAOUT;
  logic             WRT;
  logic [WIDTH-1:0] RR;
  logic             C;
`ifdef UE_ICU_ZFLAG_EN
  logic             ZF;
`endif

  modport master (
    output IR, IR_VALID, DATAIN,
    input  FL0, JMP, RTN, FLF, DATAOUT, WRT, RR, C
`ifdef UE_ICU_ZFLAG_EN
    , input ZF
`endif
  );

  modport slave (
    input  IR, IR_VALID, DATAIN,
    output FL0, JMP, RTN, FLF, DATAOUT, WRT, RR, C
`ifdef UE_ICU_ZFLAG_EN
    , output ZF
`endif
  );
endinterface

// File: rtl/ue14500_wide_icu_alu.sv
// Combinational result/carry datapath for the LD..XOR opcodes; other opcodes pass RR and C through.
module ue_icu_alu
  import ue_icu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] rr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] rr_o,
  output logic             c_o
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum  = '0;
    rr_o = rr_i;
    c_o  = c_i;
    case (op_i)
      OP_LD:   rr_o = d_i;
      OP_ADD: begin
        sum  = {1'b0, rr_i} + {1'b0, d_i} + {{WIDTH{1'b0}}, c_i};
        rr_o = sum[WIDTH-1:0];
        c_o  = sum[WIDTH];
      end
      // Subtract as add-with-complement: carry-out set means no borrow.
      OP_SUB: begin
        sum  = {1'b0, rr_i} + {1'b0, ~d_i} + {{WIDTH{1'b0}}, c_i};
        rr_o = sum[WIDTH-1:0];
        c_o  = sum[WIDTH];
      end
      OP_ONE: begin
        rr_o = '1;
        c_o  = 1'b0;
      end
      OP_NAND: rr_o = ~(rr_i & d_i);
      OP_OR:   rr_o = rr_i | d_i;
      OP_XOR:  rr_o = rr_i ^ d_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/ue14500_wide_icu.sv
// WIDTH-bit UE14500 control unit: decode, skip state machine and registered outputs.
// Define UE_ICU_ZFLAG_EN to add the registered zero flag ZF (SKZ then tests ZF).
module ue14500_wide_icu
  import ue_icu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int IEN_RESET = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  ue14500_wide_icu_if.slave  bus_if
);
  logic [WIDTH-1:0] rr_q, rr_d, dout_q, dout_d, d_masked, alu_rr;
  logic             c_q, c_d, alu_c;
  logic             ien_q, ien_d, oen_q, oen_d;
  logic             fl0_q, fl0_d, jmp_q, jmp_d, rtn_q, rtn_d, flf_q, flf_d, wrt_q, wrt_d;
  logic             rr_zero;
  skip_e            skip_q, skip_d;

  assign d_masked = bus_if.DATAIN & {WIDTH{ien_q}};

  ue_icu_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (bus_if.IR),
    .rr_i (rr_q),
    .d_i  (d_masked),
    .c_i  (c_q),
    .rr_o (alu_rr),
    .c_o  (alu_c)
  );

`ifdef UE_ICU_ZFLAG_EN
  logic zf_q, zf_d;
  assign rr_zero   = zf_q;
  assign bus_if.ZF = zf_q;
`else
  assign rr_zero = (rr_q == '0);
`endif

  always_comb begin
    rr_d   = rr_q;
    c_d    = c_q;
    dout_d = dout_q;
    ien_d  = ien_q;
    oen_d  = oen_q;
    skip_d = skip_q;
    fl0_d  = 1'b0;
    jmp_d  = 1'b0;
    rtn_d  = 1'b0;
    flf_d  = 1'b0;
    wrt_d  = 1'b0;
    if (bus_if.IR_VALID) begin
      // A pending skip swallows exactly one valid instruction, whatever it is.
      if (skip_q == SKIP_PEND) begin
        skip_d = SKIP_RUN;
      end else begin
        case (bus_if.IR)
          OP_NOP0: fl0_d = 1'b1;
          OP_LD, OP_ADD, OP_SUB, OP_ONE, OP_NAND, OP_OR, OP_XOR: begin
            rr_d = alu_rr;
            c_d  = alu_c;
          end
          OP_STO: if (oen_q) begin
            dout_d = rr_q;
            wrt_d  = 1'b1;
          end
          OP_STOC: if (oen_q) begin
            dout_d = ~rr_q;
            wrt_d  = 1'b1;
          end
          OP_IEN:  ien_d = bus_if.DATAIN[0];
          OP_OEN:  oen_d = bus_if.DATAIN[0];
          OP_JMP:  jmp_d = 1'b1;
          OP_RTN: begin
            rtn_d  = 1'b1;
            skip_d = SKIP_PEND;
          end
          OP_SKZ:  skip_d = rr_zero ? SKIP_PEND : SKIP_RUN;
          OP_NOPF: flf_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef UE_ICU_ZFLAG_EN
  assign zf_d = (rr_d == '0);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q   <= '0;
      c_q    <= 1'b0;
      dout_q <= '0;
      ien_q  <= (IEN_RESET != 0);
      oen_q  <= 1'b0;
      skip_q <= SKIP_RUN;
      fl0_q  <= 1'b0;
      jmp_q  <= 1'b0;
      rtn_q  <= 1'b0;
      flf_q  <= 1'b0;
      wrt_q  <= 1'b0;
`ifdef UE_ICU_ZFLAG_EN
      zf_q   <= 1'b1;
`endif
    end else begin
      rr_q   <= rr_d;
      c_q    <= c_d;
      dout_q <= dout_d;
      ien_q  <= ien_d;
      oen_q  <= oen_d;
      skip_q <= skip_d;
      fl0_q  <= fl0_d;
      jmp_q  <= jmp_d;
      rtn_q  <= rtn_d;
      flf_q  <= flf_d;
      wrt_q  <= wrt_d;
`ifdef UE_ICU_ZFLAG_EN
      zf_q   <= zf_d;
`endif
    end
  end

  assign bus_if.RR      = rr_q;
  assign bus_if.C       = c_q;
  assign bus_if.DATAOUT = dout_q;
  assign bus_if.FL0     = fl0_q;
  assign bus_if.JMP     = jmp_q;
  assign bus_if.RTN     = rtn_q;
  assign bus_if.FLF     = flf_q;
  assign bus_if.WRT     = wrt_q;
endmodule

// File: tb/tb_ue14500_wide_icu.sv
// Bench for ue14500_wide_icu: WIDTH=4 and WIDTH=1 instances against an instruction-level reference model.
module tb_ue14500_wide_icu;
  import ue_icu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ue14500_wide_icu_if #(.WIDTH(4)) bus4 ();
  ue14500_wide_icu_if #(.WIDTH(1)) bus1 ();

  ue14500_wide_icu #(.WIDTH(4), .IEN_RESET(0)) u_dut4 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .bus_if (bus4.slave)
  );

  ue14500_wide_icu #(.WIDTH(1), .IEN_RESET(0)) u_dut1 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .bus_if (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned rr, c, dout, ien, oen, skip, fl0, jmp, rtn, flf, wrt;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  // One instruction of the ISA evaluated with plain integer arithmetic.
  function automatic mdl_t mdl_step(mdl_t m, int w, int op, bit vld, int unsigned din);
    mdl_t n;
    int unsigned mask, d, s;
    n = m;
    n.fl0 = 0; n.jmp = 0; n.rtn = 0; n.flf = 0; n.wrt = 0;
    mask = (32'd1 << w) - 1;
    if (!vld) return n;
    if (m.skip != 0) begin
      n.skip = 0;
      return n;
    end
    d = (m.ien != 0) ? (din & mask) : 0;
    case (op)
      0:  n.fl0 = 1;
      1:  n.rr = d;
      2:  begin s = m.rr + d + m.c; n.rr = s & mask; n.c = (s >> w) & 1; end
      3:  begin s = m.rr + (~d & mask) + m.c; n.rr = s & mask; n.c = (s >> w) & 1; end
      4:  begin n.rr = mask; n.c = 0; end
      5:  n.rr = ~(m.rr & d) & mask;
      6:  n.rr = m.rr | d;
      7:  n.rr = m.rr ^ d;
      8:  if (m.oen != 0) begin n.dout = m.rr; n.wrt = 1; end
      9:  if (m.oen != 0) begin n.dout = ~m.rr & mask; n.wrt = 1; end
      10: n.ien = din & 1;
      11: n.oen = din & 1;
      12: n.jmp = 1;
      13: begin n.rtn = 1; n.skip = 1; end
      14: n.skip = (m.rr == 0) ? 1 : 0;
      default: n.flf = 1;
    endcase
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rr4",   32'(bus4.RR),      m4.rr);
    check("c4",    32'(bus4.C),       m4.c);
    check("dout4", 32'(bus4.DATAOUT), m4.dout);
    check("wrt4",  32'(bus4.WRT),     m4.wrt);
    check("fl0_4", 32'(bus4.FL0),     m4.fl0);
    check("jmp4",  32'(bus4.JMP),     m4.jmp);
    check("rtn4",  32'(bus4.RTN),     m4.rtn);
    check("flf4",  32'(bus4.FLF),     m4.flf);
    check("rr1",   32'(bus1.RR),      m1.rr);
    check("c1",    32'(bus1.C),       m1.c);
    check("dout1", 32'(bus1.DATAOUT), m1.dout);
    check("wrt1",  32'(bus1.WRT),     m1.wrt);
    check("fl0_1", 32'(bus1.FL0),     m1.fl0);
    check("jmp1",  32'(bus1.JMP),     m1.jmp);
    check("rtn1",  32'(bus1.RTN),     m1.rtn);
    check("flf1",  32'(bus1.FLF),     m1.flf);
`ifdef UE_ICU_ZFLAG_EN
    check("zf4",   32'(bus4.ZF),      (m4.rr == 0) ? 1 : 0);
    check("zf1",   32'(bus1.ZF),      (m1.rr == 0) ? 1 : 0);
`endif
  endtask

  task automatic step(input int op, input bit vld, input int unsigned din);
    logic [31:0] dv;
    dv = din;
    bus4.IR       = 4'(op);
    bus4.IR_VALID = vld;
    bus4.DATAIN   = dv[3:0];
    bus1.IR       = 4'(op);
    bus1.IR_VALID = vld;
    bus1.DATAIN   = dv[0:0];
    @(posedge clk);
    #1;
    m4 = mdl_step(m4, 4, op, vld, din);
    m1 = mdl_step(m1, 1, op, vld, din);
    compare_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus4.IR = '0; bus4.IR_VALID = 1'b0; bus4.DATAIN = '0;
    bus1.IR = '0; bus1.IR_VALID = 1'b0; bus1.DATAIN = '0;
    m4 = mdl_reset();
    m1 = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Arithmetic with input enabled.
    step(OP_IEN, 1'b1, 1);
    step(OP_ONE, 1'b1, 0);
    step(OP_ADD, 1'b1, 1);
    check("add_rr", 32'(bus4.RR), 32'h0);
    check("add_c",  32'(bus4.C),  32'h1);
    step(OP_SUB, 1'b1, 1);
    check("sub_rr", 32'(bus4.RR), 32'hF);
    check("sub_c",  32'(bus4.C),  32'h0);

    // Input masking, then stores with output disabled and enabled.
    step(OP_IEN, 1'b1, 0);
    step(OP_LD,  1'b1, 4'hA);
    check("ld_masked", 32'(bus4.RR), 32'h0);
    step(OP_IEN, 1'b1, 1);
    step(OP_LD,  1'b1, 4'hA);
    check("ld_open", 32'(bus4.RR), 32'hA);
    step(OP_STOC, 1'b1, 0);
    check("stoc_oen0_wrt", 32'(bus4.WRT), 32'h0);
    step(OP_OEN, 1'b1, 1);
    step(OP_STOC, 1'b1, 0);
    check("stoc_dout", 32'(bus4.DATAOUT), 32'h5);
    check("stoc_wrt",  32'(bus4.WRT),     32'h1);
    step(OP_NOP0, 1'b1, 0);
    check("wrt_clear", 32'(bus4.WRT), 32'h0);
    check("fl0_pulse", 32'(bus4.FL0), 32'h1);

    // SKZ skip survives stalls.
    step(OP_LD, 1'b1, 0);
    step(OP_SKZ, 1'b1, 0);
    repeat (3) step(OP_JMP, 1'b0, 0);
    check("stall_jmp", 32'(bus4.JMP), 32'h0);
    step(OP_JMP, 1'b1, 0);
    check("skipped_jmp", 32'(bus4.JMP), 32'h0);
    step(OP_JMP, 1'b1, 0);
    check("jmp_pulse", 32'(bus4.JMP), 32'h1);

    // RTN skips one instruction; SKZ with RR!=0 does not.
    step(OP_RTN, 1'b1, 0);
    check("rtn_pulse", 32'(bus4.RTN), 32'h1);
    step(OP_NOPF, 1'b1, 0);
    check("skipped_flf", 32'(bus4.FLF), 32'h0);
    step(OP_NOPF, 1'b1, 0);
    check("flf_pulse", 32'(bus4.FLF), 32'h1);
    step(OP_ONE, 1'b1, 0);
    step(OP_SKZ, 1'b1, 0);
    step(OP_JMP, 1'b1, 0);
    check("skz_nz_jmp", 32'(bus4.JMP), 32'h1);

    // Asynchronous reset while a skip is pending.
    step(OP_STO, 1'b1, 0);
    step(OP_RTN, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rr",   32'(bus4.RR),      32'h0);
    check("rst_dout", 32'(bus4.DATAOUT), 32'h0);
    check("rst_rtn",  32'(bus4.RTN),     32'h0);
    check("rst_c",    32'(bus4.C),       32'h0);
    m4 = mdl_reset();
    m1 = mdl_reset();
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(OP_NOPF, 1'b1, 0);
    check("post_rst_flf", 32'(bus4.FLF), 32'h1);

    // Random instruction stream on both widths.
    for (int i = 0; i < 1000; i++) begin
      step(int'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
